// File: rtl/inst_pcm_sched_pkg.sv
// Shared types and constants for the PCM instruction scheduler.
// FSM encodings, instruction width and length-mask helpers.
package inst_pcm_sched_pkg;

  localparam int          MAX_INST_BITS   = 512;
  localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd1_000_000;

  typedef logic [MAX_INST_BITS-1:0] inst_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } sched_st_e;

  function automatic logic len_ok(input logic [15:0] len);
    return (len != 16'd0) && (len <= 16'(MAX_INST_BITS));
  endfunction

  // keeps the top len bits of a left-justified word
  function automatic inst_t len_mask(input logic [15:0] len);
    logic [15:0] sh;
    sh = 16'(MAX_INST_BITS) - len;
    return {MAX_INST_BITS{1'b1}} << sh;
  endfunction

endpackage

// File: rtl/inst_pcm_sched_if.sv
// Source strobes and PCM TX launch bundle of the scheduler.
// master = sources/serializer side, slave = scheduler side.
interface inst_pcm_sched_if;
  import inst_pcm_sched_pkg::*;

  inst_t src0_data;
  logic  src0_valid;
  logic  src0_full;
  inst_t src1_data;
  logic  src1_valid;
  logic  src1_full;
  inst_t pcm_inst_data;
  logic  pcm_inst_data_valid;
  logic  pcm_tx_done;

  modport master (
    output src0_data, src0_valid,
    output src1_data, src1_valid,
    output pcm_tx_done,
    input  src0_full, src1_full,
    input  pcm_inst_data, pcm_inst_data_valid
  );

  modport slave (
    input  src0_data, src0_valid,
    input  src1_data, src1_valid,
    input  pcm_tx_done,
    output src0_full, src1_full,
    output pcm_inst_data, pcm_inst_data_valid
  );

endinterface

// File: rtl/inst_src_buf.sv
// One-entry source holding buffer with saturating drop counter.
// A strobe landing on the release cycle reloads instead of clearing.
module inst_src_buf
  import inst_pcm_sched_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst_n,
  input  inst_t      din,
  input  logic       vld,
  input  logic       clr,
  output inst_t      dout,
  output logic       full,
  output logic [7:0] drop_cnt
);

  logic drop;

  assign drop = vld && full && !clr;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      full     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (vld && !drop) begin
        dout <= din;
        full <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
      if (drop && drop_cnt != 8'hff)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/inst_pcm_sched.sv
// Round-robin launcher of two instruction sources onto the PCM TX path.
// Waits for frame done (or timeout) and a programmable gap between launches.
module inst_pcm_sched
  import inst_pcm_sched_pkg::*;
#(
  parameter int          U_DLY       = 1,
  parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  input  logic [15:0]    cfg_ins_length,
  input  logic [15:0]    cfg_gap_cyc,
  inst_pcm_sched_if.slave bus,
  output logic           sched_busy,
  output logic           err_len,
  output logic           err_timeout,
  output logic [7:0]     drop_cnt0,
  output logic [7:0]     drop_cnt1
);

  if (U_DLY < 0) begin : g_udly_chk
  end

  sched_st_e   st, st_nxt;
  logic        last_grant, grant, take;
  logic        clr0, clr1, full0, full1;
  logic        launch, len_bad, tmo_hit, gap_load;
  logic [23:0] tmo_cnt;
  logic [15:0] gap_cnt;
  inst_t       buf0, buf1, inst_q;
  logic        inst_vld_q;

  inst_src_buf u_buf0 (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .din      (bus.src0_data),
    .vld      (bus.src0_valid),
    .clr      (clr0),
    .dout     (buf0),
    .full     (full0),
    .drop_cnt (drop_cnt0)
  );

  inst_src_buf u_buf1 (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .din      (bus.src1_data),
    .vld      (bus.src1_valid),
    .clr      (clr1),
    .dout     (buf1),
    .full     (full1),
    .drop_cnt (drop_cnt1)
  );

  assign bus.src0_full           = full0;
  assign bus.src1_full           = full1;
  assign bus.pcm_inst_data       = inst_q;
  assign bus.pcm_inst_data_valid = inst_vld_q;
  assign sched_busy              = (st != ST_IDLE);

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      full0 && full1:  grant = !last_grant;
      full1 && !full0: grant = 1'b1;
      default:         grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    take     = 1'b0;
    clr0     = 1'b0;
    clr1     = 1'b0;
    launch   = 1'b0;
    len_bad  = 1'b0;
    tmo_hit  = 1'b0;
    gap_load = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (full0 || full1) begin
          take   = 1'b1;
          st_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        clr0 = !last_grant;
        clr1 = last_grant;
        if (len_ok(cfg_ins_length)) begin
          launch = 1'b1;
          st_nxt = ST_WAIT;
        end else begin
          len_bad = 1'b1;
          st_nxt  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.pcm_tx_done) begin
          gap_load = 1'b1;
          st_nxt   = ST_GAP;
        end else if (tmo_cnt == TIMEOUT_CYC - 24'd1) begin
          tmo_hit  = 1'b1;
          gap_load = 1'b1;
          st_nxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= 16'd1) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      inst_q      <= '0;
      inst_vld_q  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      inst_vld_q  <= launch;
      err_len     <= len_bad;
      err_timeout <= tmo_hit;
      if (take) last_grant <= grant;
      if (launch)
        inst_q <= (last_grant ? buf1 : buf0)
                  & len_mask(cfg_ins_length);
      tmo_cnt <= (st == ST_WAIT) ? tmo_cnt + 24'd1 : '0;
      if (gap_load)
        gap_cnt <= cfg_gap_cyc;
      else if (st == ST_GAP && gap_cnt != 16'd0)
        gap_cnt <= gap_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_pcm_sched.sv
// Self-checking bench for inst_pcm_sched: vector table, launch
// scoreboard and hand-written multi-cycle sequences.
module tb_inst_pcm_sched;
  import inst_pcm_sched_pkg::*;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_len, cfg_gap;
  logic        busy, err_len, err_timeout;
  logic [7:0]  drop_cnt0, drop_cnt1;

  int    n_chk = 0;
  int    n_err = 0;
  inst_t sb[$];

  inst_pcm_sched_if bus();

  inst_pcm_sched #(
    .U_DLY       (1),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .cfg_ins_length (cfg_len),
    .cfg_gap_cyc    (cfg_gap),
    .bus            (bus),
    .sched_busy     (busy),
    .err_len        (err_len),
    .err_timeout    (err_timeout),
    .drop_cnt0      (drop_cnt0),
    .drop_cnt1      (drop_cnt1)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] len;
    int          sel;
    inst_t       data;
    logic        exp_err;
  } vec_t;

  vec_t vt[8];

  function automatic vec_t mk(input int len, input int sel,
                              input inst_t d, input logic e);
    vec_t v;
    v.len     = 16'(len);
    v.sel     = sel;
    v.data    = d;
    v.exp_err = e;
    return v;
  endfunction

  function automatic inst_t pat(input int unsigned s);
    inst_t r;
    for (int k = 0; k < 16; k++)
      r[k*32 +: 32] = (s * 32'h9E37_79B9) ^ (k * 32'h0101_0101)
                      ^ 32'h5A5A_0000;
    return r;
  endfunction

  // top len bits kept, everything below zero
  function automatic inst_t exp_word(input inst_t d, input int len);
    inst_t r;
    r = '0;
    for (int b = 0; b < len && b < 512; b++)
      r[511-b] = d[511-b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic pulse_src(input int sel, input inst_t d);
    if (sel == 0) begin
      bus.src0_valid = 1'b1;
      bus.src0_data  = d;
    end else begin
      bus.src1_valid = 1'b1;
      bus.src1_data  = d;
    end
    tick();
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
  endtask

  task automatic drive_both(input inst_t d0, input inst_t d1);
    bus.src0_valid = 1'b1;
    bus.src0_data  = d0;
    bus.src1_valid = 1'b1;
    bus.src1_data  = d1;
    tick();
    bus.src0_valid = 1'b0;
    bus.src1_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.pcm_tx_done = 1'b1;
    tick();
    bus.pcm_tx_done = 1'b0;
  endtask

  // which: 0 launch strobe, 1 err_len, 2 err_timeout
  task automatic wait_evt(input int which, input int max,
                          output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((which == 0 && bus.pcm_inst_data_valid) ||
          (which == 1 && err_len) ||
          (which == 2 && err_timeout)) begin
        cyc = i;
        break;
      end
    end
  endtask

  always @(negedge clk_sys) begin
    if (bus.pcm_inst_data_valid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL launch_unexpected act=%h exp=none",
                 bus.pcm_inst_data);
      end else begin
        inst_t e;
        e = sb.pop_front();
        if (bus.pcm_inst_data !== e) begin
          n_err++;
          $display("FAIL launch_data act=%h exp=%h",
                   bus.pcm_inst_data, e);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    inst_t d0, d1, last_exp, ones;
    ones = '1;
    last_exp = '0;

    vt[0] = mk(64,  0, ones,   1'b0);
    vt[1] = mk(512, 1, pat(1), 1'b0);
    vt[2] = mk(1,   0, pat(2), 1'b0);
    vt[3] = mk(0,   0, ones,   1'b1);
    vt[4] = mk(511, 1, pat(3), 1'b0);
    vt[5] = mk(600, 1, ones,   1'b1);
    vt[6] = mk(513, 0, pat(4), 1'b1);
    vt[7] = mk(100, 1, pat(5), 1'b0);

    rst_n           = 1'b0;
    cfg_len         = '0;
    cfg_gap         = '0;
    bus.src0_valid  = 1'b0;
    bus.src1_valid  = 1'b0;
    bus.src0_data   = '0;
    bus.src1_data   = '0;
    bus.pcm_tx_done = 1'b0;
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_valid", bus.pcm_inst_data_valid, 0);
    chk("rst_data0", bus.pcm_inst_data == '0, 1);
    chk("rst_full",  {bus.src0_full, bus.src1_full}, 0);
    chk("rst_err",   {err_len, err_timeout}, 0);
    chk("rst_drop",  {drop_cnt0, drop_cnt1}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      cfg_len = vt[i].len;
      cfg_gap = 16'd0;
      if (!vt[i].exp_err) begin
        last_exp = exp_word(vt[i].data, int'(vt[i].len));
        sb.push_back(last_exp);
      end
      pulse_src(vt[i].sel, vt[i].data);
      wait_evt(vt[i].exp_err ? 1 : 0, 10, cyc);
      chk($sformatf("v%0d_lat", i), cyc + 1, 3);
      chk($sformatf("v%0d_clr", i),
          vt[i].sel != 0 ? bus.src1_full : bus.src0_full, 0);
      if (vt[i].exp_err) begin
        chk($sformatf("v%0d_idle", i), busy, 0);
        tick();
        chk($sformatf("v%0d_errw", i), err_len, 0);
      end else begin
        tick();
        tick();
        pulse_done();
        chk($sformatf("v%0d_gap", i), busy, 1);
        tick();
        chk($sformatf("v%0d_idle", i), busy, 0);
      end
      chk($sformatf("v%0d_hold", i),
          bus.pcm_inst_data == last_exp, 1);
    end

    cfg_len = 16'd64;
    cfg_gap = 16'd0;
    d0 = pat(10);
    d1 = pat(11);
    sb.push_back(exp_word(d0, 64));
    sb.push_back(exp_word(d1, 64));
    drive_both(d0, d1);
    wait_evt(0, 10, cyc);
    chk("s2_lat", cyc + 1, 3);
    chk("s2_src1_held", bus.src1_full, 1);
    tick();
    pulse_done();
    wait_evt(0, 10, cyc);
    chk("s2_second", cyc, 3);
    tick();
    pulse_done();
    tick();
    d0 = pat(12);
    d1 = pat(13);
    sb.push_back(exp_word(d0, 64));
    sb.push_back(exp_word(d1, 64));
    pulse_src(1, d0);
    tick();
    pulse_src(1, d1);
    chk("s2_reload_vld", bus.pcm_inst_data_valid, 1);
    chk("s2_reload_full", bus.src1_full, 1);
    chk("s2_no_drop", drop_cnt1, 0);
    tick();
    pulse_done();
    wait_evt(0, 10, cyc);
    chk("s2_src1_again", cyc, 3);
    tick();
    pulse_done();
    tick();
    d0 = pat(14);
    sb.push_back(exp_word(d0, 64));
    pulse_src(0, d0);
    wait_evt(0, 10, cyc);
    tick();
    pulse_done();
    tick();
    d0 = pat(15);
    d1 = pat(16);
    sb.push_back(exp_word(d1, 64));
    sb.push_back(exp_word(d0, 64));
    drive_both(d0, d1);
    wait_evt(0, 10, cyc);
    chk("s2_rr_lat", cyc + 1, 3);
    chk("s2_src0_held", bus.src0_full, 1);
    tick();
    pulse_done();
    wait_evt(0, 10, cyc);
    chk("s2_rr_second", cyc, 3);
    tick();
    pulse_done();
    tick();

    cfg_len = 16'd128;
    d0 = pat(20);
    sb.push_back(exp_word(d0, 128));
    pulse_src(1, d0);
    wait_evt(0, 10, cyc);
    d1 = pat(21);
    sb.push_back(exp_word(d1, 128));
    pulse_src(0, d1);
    pulse_src(0, pat(22));
    pulse_src(0, pat(23));
    chk("s3_drop2", drop_cnt0, 2);
    cfg_gap = 16'd1000;
    pulse_done();
    cfg_gap = 16'd0;
    for (int k = 0; k < 300; k++) pulse_src(0, pat(100 + k));
    chk("s3_drop_sat", drop_cnt0, 255);
    chk("s3_drop1", drop_cnt1, 0);
    wait_evt(0, 1000, cyc);
    chk("s3_gap_len", cyc + 300, 1002);
    tick();
    pulse_done();
    tick();

    cfg_len = 16'd32;
    cfg_gap = 16'd5;
    d0 = pat(30);
    d1 = pat(31);
    sb.push_back(exp_word(d0, 32));
    pulse_src(1, d0);
    wait_evt(0, 10, cyc);
    chk("s5_lat", cyc + 1, 3);
    sb.push_back(exp_word(d1, 32));
    pulse_src(0, d1);
    wait_evt(2, 200, cyc);
    chk("s5_tmo_at", cyc + 1, 100);
    chk("s5_no_errlen", err_len, 0);
    tick();
    chk("s5_tmo_width", err_timeout, 0);
    wait_evt(0, 20, cyc);
    chk("s5_gap_launch", cyc + 1, 7);
    cfg_gap = 16'd0;
    tick();
    pulse_done();
    tick();

    cfg_len = 16'd64;
    d0 = pat(40);
    sb.push_back(exp_word(d0, 64));
    pulse_src(0, d0);
    wait_evt(0, 10, cyc);
    tick();
    pulse_src(1, pat(41));
    tick();
    rst_n = 1'b0;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_data0", bus.pcm_inst_data == '0, 1);
    chk("s6_full1", bus.src1_full, 0);
    chk("s6_drop0", drop_cnt0, 0);
    repeat (2) tick();
    d1 = pat(42);
    sb.push_back(exp_word(d1, 64));
    rst_n = 1'b1;
    pulse_src(1, d1);
    wait_evt(0, 10, cyc);
    chk("s6_lat", cyc + 1, 3);
    tick();
    pulse_done();
    repeat (3) tick();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
